bitty_fetch_unit: RTL and testbench
===================================

Name: bitty_fetch_unit

Overview:
- Instruction-supply side of the Bitty core's run/done handshake. Holds the program in an internal instruction memory and steps a program counter.
- Presents each instruction on `instruction`, pulses `run` for one cycle, then waits for the core's `done` pulse before fetching the next word.
- Sits beside the Bitty core top. Its `instruction`/`run` outputs connect directly to the core's `instruction`/`run` inputs, and the core's `done` returns here.

Parameters:
- ADDR_W, 8, instruction memory address width; DEPTH = 2**ADDR_W words of 16 bits.
- TIMEOUT, 255, max cycles in WAIT without `done` before an error halt; must be ≥1.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin execution at address 0 (accepted in IDLE or HALT only)
- stop  in  1  request halt after the current instruction completes
- end_addr  in  ADDR_W  address of last instruction; sampled at start
- mem_we  in  1  program-load write enable (accepted only when busy=0)
- mem_waddr  in  ADDR_W  program-load address
- mem_wdata  in  16  program-load data
- done  in  1  one-cycle completion pulse from the core
- instruction  out  16  instruction presented to the core; held stable from ISSUE through WAIT
- run  out  1  one-cycle pulse launching the core
- pc  out  ADDR_W  address of the instruction currently fetched/executing
- busy  out  1  high in FETCH, ISSUE, WAIT
- halted  out  1  high in HALT
- timeout_err  out  1  sticky; set on watchdog expiry, cleared by start or reset
- instr_count  out  16  instructions completed since last start; saturates at 16'hFFFF

Behaviour:
- Reset (async, immediate): state=IDLE, pc=0, instruction=0, run=0, busy=0, halted=0, timeout_err=0, instr_count=0, stop request cleared, watchdog=0.
- Reset does not clear memory contents.
- Memory: synchronous write when mem_we && !busy; writes while busy are dropped.
- Memory: synchronous read, 1-cycle latency, registered into `instruction`.
- IDLE → FETCH on start:
  - pc←0, end latched, instr_count←0, timeout_err←0, stop request cleared.
- FETCH (1 cycle): read mem[pc]; `instruction` loads at the end of this cycle; → ISSUE.
- ISSUE (1 cycle): run=1; watchdog←0; → WAIT.
- WAIT: run=0; `instruction` held; watchdog increments each cycle.
  - On done=1:
    - instr_count increments (saturating).
    - If pc==end_latched or stop request pending → HALT.
    - Otherwise pc←pc+1 (wraps DEPTH-1→0) and → FETCH.
  - If watchdog reaches TIMEOUT without done: timeout_err←1, → HALT, pc unchanged.
- HALT: halted=1; `instruction` and pc hold. start → same action as from IDLE.
- `done` outside WAIT is ignored. `done` in the same cycle the watchdog expires counts as completion; no error is raised.
- `stop` is latched into a sticky request in any busy state and takes effect at the next done. `stop` in IDLE/HALT is ignored.
- `start` while busy is ignored.
- `start` and `stop` asserted in the same cycle in IDLE: start wins; the stop is ignored.
- Minimum instruction period: 3 cycles (FETCH, ISSUE, WAIT with done on the first WAIT cycle).
- The run pulse is never asserted twice without an intervening done or a halt/reset.
- end_addr < current pc is not special: execution wraps until pc equals end_addr.

Test Plan:
1. Basic run:
   - Stimulus: reset; load mem[0..2]=16'h0001,16'h0002,16'h0003; end_addr=2; start; core model returns done 2 cycles after each run.
   - Required: exactly three run pulses with instruction 0001, 0002, 0003 in order; then halted=1, pc=2, instr_count=3, timeout_err=0.
2. Stop request:
   - Stimulus: end_addr=8'hFF, program of 10 words; assert stop for one cycle during the 4th instruction's WAIT.
   - Required: halt after its done; instr_count=4, pc=3.
3. Watchdog:
   - Stimulus: TIMEOUT=4; core never returns done.
   - Required: run pulses once; after 4 WAIT cycles timeout_err=1, halted=1, pc=0.
   - Follow-up: start then clears timeout_err and restarts at pc=0.
4. Load protection:
   - Stimulus: while busy, mem_we to address 1 with 16'hDEAD.
   - Required: the write is ignored, and the later fetch of address 1 returns the originally loaded word.
5. Async reset mid-WAIT:
   - Stimulus: assert reset between clock edges.
   - Required: run=0, busy=0, pc=0, instr_count=0 immediately; the next start re-executes from address 0 with memory intact.
6. Wrap and spurious done:
   - Stimulus: ADDR_W=2, end_addr=1, start.
   - Required: the core sees addresses 0,1 then halts.
   - Stimulus: inject done during FETCH.
   - Required: no pc change and no count change.

Source files
------------

// File: rtl/bitty_fetch_unit.sv
// Purpose : instruction supply for the Bitty core; owns program memory, steps pc, run/done handshake.
// Latency : 3 cycles minimum per instruction (FETCH, ISSUE, WAIT with done in the first WAIT cycle).
// Backpressure: holds the instruction in WAIT until the core returns done or the watchdog expires.
//
// Ports:
//   clk, reset               - clock, async active-high reset
//   start / stop             - begin at address 0 (IDLE/HALT only) / halt after the current instruction
//   end_addr                 - last instruction address, sampled on an accepted start
//   mem_we/mem_waddr/mem_wdata - program load port, writes dropped while busy
//   done                     - one-cycle completion pulse from the core
//   instruction, run         - word presented to the core and its one-cycle launch pulse
//   pc, busy, halted         - fetch address and state flags
//   timeout_err, instr_count - sticky watchdog error and saturating completion counter
module bitty_fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [15:0]       mem_wdata,
    input  logic              done,
    output logic [15:0]       instruction,
    output logic              run,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              timeout_err,
    output logic [15:0]       instr_count
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_end;
    logic [15:0]       r_instr;
    logic [WD_W-1:0]   r_wdog;
    logic              r_stop_req;
    logic              r_terr;
    logic [15:0]       r_count;

    logic w_busy;
    logic w_start_ok;
    logic w_done_ok;
    logic w_expire;
    logic w_finish;

    assign w_busy     = (r_state == S_FETCH) || (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_HALT));
    assign w_done_ok  = (r_state == S_WAIT) && done;
    // done arriving on the expiry cycle wins: expiry only counts when done is absent.
    assign w_expire   = (r_state == S_WAIT) && !done && (r_wdog == WD_W'(TIMEOUT - 1));
    // A stop presented in the same cycle as done is honoured along with the latched request.
    assign w_finish   = w_done_ok && ((r_pc == r_end) || r_stop_req || stop);

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_FETCH;
            S_FETCH: w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (w_done_ok)     w_next = w_finish ? S_HALT : S_FETCH;
                else if (w_expire) w_next = S_HALT;
            end
            S_HALT:  if (start) w_next = S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Program memory: no reset so a reset mid-program keeps the loaded image.
    always_ff @(posedge clk) begin
        if (mem_we && !w_busy) r_mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= '0;
            r_end      <= '0;
            r_instr    <= '0;
            r_wdog     <= '0;
            r_stop_req <= 1'b0;
            r_terr     <= 1'b0;
            r_count    <= '0;
        end else if (w_start_ok) begin
            // start beats a simultaneous stop: the request is cleared, not set.
            r_pc       <= '0;
            r_end      <= end_addr;
            r_count    <= '0;
            r_terr     <= 1'b0;
            r_stop_req <= 1'b0;
        end else begin
            if (w_busy && stop) r_stop_req <= 1'b1;
            case (r_state)
                S_FETCH: r_instr <= r_mem[r_pc];
                S_ISSUE: r_wdog  <= '0;
                S_WAIT: begin
                    if (w_done_ok) begin
                        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
                        if (!w_finish) r_pc <= r_pc + ADDR_W'(1);
                    end else if (w_expire) begin
                        r_terr <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore outputs
    always_comb begin
        run         = (r_state == S_ISSUE);
        busy        = w_busy;
        halted      = (r_state == S_HALT);
        instruction = r_instr;
        pc          = r_pc;
        timeout_err = r_terr;
        instr_count = r_count;
    end

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Purpose : directed self-checking bench for bitty_fetch_unit (8-bit and 2-bit address instances).
// Latency : inputs driven and outputs sampled 2 time units after each rising edge.
// Backpressure: a core model returns done a fixed delay after each run; the small instance is driven by hand.
module tb_bitty_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;

    // Instance A: ADDR_W=8, TIMEOUT=4
    logic        start, stop, mem_we, core_done;
    logic [7:0]  end_addr, mem_waddr;
    logic [15:0] mem_wdata;
    logic [15:0] instruction, instr_count;
    logic        run, busy, halted, timeout_err;
    logic [7:0]  pc;

    // Instance B: ADDR_W=2, TIMEOUT=4
    logic        start_b, stop_b, mem_we_b, done_b;
    logic [1:0]  end_addr_b, mem_waddr_b;
    logic [15:0] mem_wdata_b;
    logic [15:0] instruction_b, instr_count_b;
    logic        run_b, busy_b, halted_b, timeout_err_b;
    logic [1:0]  pc_b;

    int errors = 0;
    int checks = 0;

    // Core model state
    int          nlog = 0;
    int          cnt  = 0;
    int          dly  = 2;
    bit          core_en = 1'b1;
    logic [15:0] log_instr [256];

    always #5 clk = ~clk;

    bitty_fetch_unit #(.ADDR_W(8), .TIMEOUT(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .end_addr(end_addr),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .done(core_done),
        .instruction(instruction), .run(run), .pc(pc), .busy(busy), .halted(halted),
        .timeout_err(timeout_err), .instr_count(instr_count)
    );

    bitty_fetch_unit #(.ADDR_W(2), .TIMEOUT(4)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .stop(stop_b), .end_addr(end_addr_b),
        .mem_we(mem_we_b), .mem_waddr(mem_waddr_b), .mem_wdata(mem_wdata_b), .done(done_b),
        .instruction(instruction_b), .run(run_b), .pc(pc_b), .busy(busy_b), .halted(halted_b),
        .timeout_err(timeout_err_b), .instr_count(instr_count_b)
    );

    // Core model for instance A: logs each run and returns done dly cycles later.
    always @(negedge clk) begin
        core_done = 1'b0;
        if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) core_done = 1'b1;
        end
        if (run === 1'b1) begin
            log_instr[nlog % 256] = instruction;
            nlog = nlog + 1;
            if (core_en) cnt = dly;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        mem_waddr = a;
        mem_wdata = d;
        mem_we    = 1'b1;
        step();
        mem_we    = 1'b0;
    endtask

    task automatic load_b(input logic [1:0] a, input logic [15:0] d);
        mem_waddr_b = a;
        mem_wdata_b = d;
        mem_we_b    = 1'b1;
        step();
        mem_we_b    = 1'b0;
    endtask

    task automatic kick(input logic [7:0] ea);
        end_addr = ea;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (halted !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check(tag, halted, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int base;
        int n;
        reset = 1'b1;
        start = 0; stop = 0; mem_we = 0; end_addr = 0; mem_waddr = 0; mem_wdata = 0;
        start_b = 0; stop_b = 0; mem_we_b = 0; done_b = 0; end_addr_b = 0; mem_waddr_b = 0; mem_wdata_b = 0;
        step();
        step();
        // Reset state
        check("rst_run", run, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", pc, 0);
        check("rst_instr", instruction, 0);
        check("rst_count", instr_count, 0);
        check("rst_terr", timeout_err, 0);
        reset = 1'b0;
        step();

        // 1. Basic run
        load(8'd0, 16'h0001);
        load(8'd1, 16'h0002);
        load(8'd2, 16'h0003);
        base = nlog;
        kick(8'd2);
        check("t1_busy", busy, 1);
        wait_halt("t1_halt");
        check("t1_nrun", nlog - base, 3);
        check("t1_i0", log_instr[base % 256], 16'h0001);
        check("t1_i1", log_instr[(base + 1) % 256], 16'h0002);
        check("t1_i2", log_instr[(base + 2) % 256], 16'h0003);
        check("t1_pc", pc, 2);
        check("t1_count", instr_count, 3);
        check("t1_terr", timeout_err, 0);
        check("t1_busy_end", busy, 0);

        // 2. Stop request during the 4th instruction's WAIT
        for (int i = 0; i < 10; i++) load(8'(i), 16'h0100 + 16'(i));
        base = nlog;
        kick(8'hFF);
        n = 0;
        while (nlog - base < 4 && n < 100) begin
            step();
            n++;
        end
        check("t2_reach4", nlog - base, 4);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_halt("t2_halt");
        check("t2_count", instr_count, 4);
        check("t2_pc", pc, 3);
        check("t2_nrun", nlog - base, 4);

        // 3. Watchdog: the core never answers
        core_en = 1'b0;
        base = nlog;
        kick(8'd0);
        step();
        check("t3_run", run, 1);
        step();
        repeat (3) step();
        check("t3_wait4_halted", halted, 0);
        check("t3_wait4_busy", busy, 1);
        step();
        check("t3_halted", halted, 1);
        check("t3_terr", timeout_err, 1);
        check("t3_pc", pc, 0);
        check("t3_nrun", nlog - base, 1);
        core_en = 1'b1;
        kick(8'd0);
        check("t3_restart_terr", timeout_err, 0);
        check("t3_restart_pc", pc, 0);
        check("t3_restart_busy", busy, 1);
        wait_halt("t3_restart_halt");
        check("t3_restart_count", instr_count, 1);
        check("t3_restart_terr_end", timeout_err, 0);

        // 4. Load protection while busy
        base = nlog;
        kick(8'd2);
        mem_waddr = 8'd1;
        mem_wdata = 16'hDEAD;
        mem_we    = 1'b1;
        step();
        mem_we    = 1'b0;
        wait_halt("t4_halt");
        check("t4_nrun", nlog - base, 3);
        check("t4_word1", log_instr[(base + 1) % 256], 16'h0101);

        // 5. Async reset in the middle of WAIT
        base = nlog;
        kick(8'd2);
        n = 0;
        while (nlog - base < 2 && n < 100) begin
            step();
            n++;
        end
        check("t5_pre_pc", pc, 1);
        check("t5_pre_count", instr_count, 1);
        #1 reset = 1'b1;
        #1;
        check("t5_run", run, 0);
        check("t5_busy", busy, 0);
        check("t5_pc", pc, 0);
        check("t5_count", instr_count, 0);
        reset = 1'b0;
        repeat (3) step();
        base = nlog;
        kick(8'd2);
        wait_halt("t5_halt");
        check("t5_nrun", nlog - base, 3);
        check("t5_i0", log_instr[base % 256], 16'h0100);
        check("t5_i1", log_instr[(base + 1) % 256], 16'h0101);
        check("t5_i2", log_instr[(base + 2) % 256], 16'h0102);
        check("t5_end_count", instr_count, 3);
        check("t5_end_pc", pc, 2);

        // 6. Small instance: end_addr=1, spurious done during FETCH
        for (int i = 0; i < 4; i++) load_b(2'(i), 16'hA000 + 16'(i));
        end_addr_b = 2'd1;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        check("t6_fetch_busy", busy_b, 1);
        done_b = 1'b1;
        step();
        done_b = 1'b0;
        check("t6_spur_pc", pc_b, 0);
        check("t6_spur_count", instr_count_b, 0);
        check("t6_run0", run_b, 1);
        check("t6_instr0", instruction_b, 16'hA000);
        step();
        check("t6_wait_run", run_b, 0);
        done_b = 1'b1;
        step();
        done_b = 1'b0;
        check("t6_pc1", pc_b, 1);
        check("t6_count1", instr_count_b, 1);
        step();
        check("t6_run1", run_b, 1);
        check("t6_instr1", instruction_b, 16'hA001);
        step();
        done_b = 1'b1;
        step();
        done_b = 1'b0;
        check("t6_halted", halted_b, 1);
        check("t6_pc_end", pc_b, 1);
        check("t6_count_end", instr_count_b, 2);
        check("t6_terr", timeout_err_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
